multdiv_wb_tag_ctrl: RTL and testbench

//  Tracks the one in-flight multi-cycle MULT/DIV operation in the CPU.

---
 rtl/multdiv_wb_tag_ctrl.sv | 80 ++++++++
 tb/tb_multdiv_wb_tag_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/multdiv_wb_tag_ctrl.sv
// multdiv_wb_tag_ctrl: tracks the in-flight MULT/DIV op, presents its writeback tag and raises RAW stalls.
// Optional MULTDIV_EARLY_TERM_EN: divide-by-zero skips RUN and completes the cycle after issue.
module multdiv_wb_tag_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_mult_i,
  input  logic       start_div_i,
  input  logic [4:0] rd_i,
  input  logic       div_by_zero_i,
  input  logic [4:0] rs_a_i,
  input  logic [4:0] rs_b_i,
  output logic       busy_o,
  output logic       result_ready_o,
  output logic       wb_en_o,
  output logic [4:0] wb_rd_o,
  output logic       exception_o,
  output logic       hazard_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic             div_q, div_d, dbz_q, dbz_d;
  logic             start, is_div;
  assign start  = start_mult_i | start_div_i;
  assign is_div = start_div_i & ~start_mult_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    if (state_q == RUN) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == CNT_W'(1)) ? DONE : RUN;
    end else if (start) begin
      rd_d    = rd_i;
      div_d   = is_div;
      dbz_d   = is_div & div_by_zero_i;
      cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
      state_d = RUN;
`ifdef MULTDIV_EARLY_TERM_EN
      if (is_div & div_by_zero_i) begin
        cnt_d   = '0;
        state_d = DONE;
      end
`endif
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
    end
  end
  // rd_q keeps its last value in IDLE, so the tag is masked by busy
  assign busy_o         = state_q != IDLE;
  assign result_ready_o = state_q == DONE;
  assign wb_en_o        = result_ready_o & (rd_q != 5'd0);
  assign exception_o    = result_ready_o & div_q & dbz_q;
  assign wb_rd_o        = busy_o ? rd_q : 5'd0;
  assign hazard_o       = busy_o & (rd_q != 5'd0) & ((rs_a_i == rd_q) | (rs_b_i == rd_q));
endmodule

// File: tb/tb_multdiv_wb_tag_ctrl.sv
// tb_multdiv_wb_tag_ctrl: directed stimulus with a result scoreboard for multdiv_wb_tag_ctrl.
module tb_multdiv_wb_tag_ctrl;
  localparam int MC = 32;
  localparam int DC = 32;
`ifdef MULTDIV_EARLY_TERM_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = DC;
`endif
  logic clk = 0, rst_n = 0, sm = 0, sd = 0, dbz = 0;
  logic [4:0] rd = 0, ra = 0, rb = 0;
  logic busy, rr, wb_en, exc, haz;
  logic [4:0] wb_rd;
  typedef struct {int cyc; logic [4:0] rd; logic en; logic ex;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  multdiv_wb_tag_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_mult_i(sm), .start_div_i(sd), .rd_i(rd),
    .div_by_zero_i(dbz), .rs_a_i(ra), .rs_b_i(rb), .busy_o(busy),
    .result_ready_o(rr), .wb_en_o(wb_en), .wb_rd_o(wb_rd), .exception_o(exc),
    .hazard_o(haz)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue(input logic m, input logic d, input logic z, input logic [4:0] r);
    exp_t e;
    e.cyc = cyc + (m ? MC : (z ? DBZ_LAT : DC));
    e.rd  = r;
    e.en  = r != 5'd0;
    e.ex  = !m && d && z;
    q.push_back(e);
    sm = m; sd = d; dbz = z; rd = r;
    tick();
    sm = 0; sd = 0; dbz = 0; rd = 0;
  endtask
  always @(negedge clk) begin
    if (rst_n && rr) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: result_ready=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_cycle", cyc, e.cyc);
        chk("res_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("res_wb_en", {31'd0, wb_en}, {31'd0, e.en});
        chk("res_exception", {31'd0, exc}, {31'd0, e.ex});
      end
    end
  end
  initial begin
    int n;
    #2;
    chk("reset_outputs", {26'd0, busy, rr, wb_en, exc, haz, wb_rd}, 32'd0);
    tick(2);
    rst_n = 1;
    tick();
    n = cyc;
    issue(1, 0, 0, 5'd7);
    chk("mult_busy_first", {31'd0, busy}, 32'd1);
    chk("mult_wb_rd", {27'd0, wb_rd}, 32'd7);
    tick(2);
    sd = 1; rd = 5'd20;
    tick();
    sd = 0; rd = 0;
    chk("start_in_run_ignored", {27'd0, wb_rd}, 32'd7);
    tick(n + MC - cyc);
    chk("mult_busy_last", {31'd0, busy}, 32'd1);
    tick();
    chk("idle_after_done", {26'd0, busy, wb_rd}, 32'd0);
    issue(0, 1, 0, 5'd0);
    ra = 0; rb = 0;
    #1 chk("hazard_rd0", {31'd0, haz}, 32'd0);
    tick(DC);
    chk("div_r0_idle", {31'd0, busy}, 32'd0);
    n = cyc;
    issue(1, 0, 0, 5'd12);
    ra = 12;
    #1 chk("hazard_rs_a", {31'd0, haz}, 32'd1);
    ra = 3; rb = 3;
    #1 chk("hazard_none", {31'd0, haz}, 32'd0);
    rb = 12;
    #1 chk("hazard_rs_b", {31'd0, haz}, 32'd1);
    tick(n + MC - cyc);
    #1 chk("hazard_in_done", {31'd0, haz}, 32'd1);
    ra = 0; rb = 0;
    issue(1, 0, 0, 5'd9);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_wb_rd", {27'd0, wb_rd}, 32'd9);
    tick(MC);
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    issue(0, 1, 1, 5'd4);
    tick(DBZ_LAT);
    chk("dbz_idle", {31'd0, busy}, 32'd0);
    issue(1, 1, 1, 5'd11);
    tick(MC);
    chk("both_idle", {31'd0, busy}, 32'd0);
    sm = 1; rd = 5'd15;
    tick();
    sm = 0; rd = 0;
    tick(9);
    rst_n = 0;
    #1 chk("reset_mid_run", {26'd0, busy, wb_rd}, 32'd0);
    tick();
    rst_n = 1;
    tick(MC + 5);
    chk("pending_results", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
